// File: rtl/accum_frame_monitor.sv
// Frame monitor behind the 4-bit add-accumulator: counts carry-outs per frame of FRAME_LEN results
// and queues one record per frame in a 2-deep FIFO. Optional drop counter: ACCUM_MON_DROP_CNT_EN.
module accum_frame_monitor #(
  parameter int FRAME_LEN = 8,
  parameter int WRAP_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        accum,
  input  logic              overflow,
  input  logic              acc_valid,
  input  logic              clear,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WRAP_W+4:0] out_data,
  output logic              busy,
  output logic [7:0]        drop_count
);

  // state | meaning
  // IDLE  | no frame in progress, busy=0
  // RUN   | frame in progress, busy=1
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int              REC_W    = WRAP_W + 5;
  localparam logic [7:0]      LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d, wraps_inc;
  logic              sat_q, sat_d, sat_inc;
  logic              push;
  logic [REC_W-1:0]  push_rec;

  logic [REC_W-1:0]  head_q, head_d;
  logic [REC_W-1:0]  tail_q, tail_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic              pop;

  // This sample's contribution, applied to either the stored totals or the record.
  always_comb begin
    wraps_inc = wraps_q;
    sat_inc   = sat_q;
    if (overflow) begin
      if (wraps_q == WRAP_MAX) begin
        sat_inc = 1'b1;
      end else begin
        wraps_inc = wraps_q + WRAP_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wraps_d  = wraps_q;
    sat_d    = sat_q;
    push     = 1'b0;
    push_rec = '0;
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wraps_d = '0;
      sat_d   = 1'b0;
    end else if (acc_valid) begin
      state_d = S_RUN;
      if (cnt_q == LAST_IDX) begin
        push     = 1'b1;
        push_rec = {sat_inc, wraps_inc, accum};
        cnt_d    = '0;
        wraps_d  = '0;
        sat_d    = 1'b0;
      end else begin
        cnt_d   = cnt_q + 8'd1;
        wraps_d = wraps_inc;
        sat_d   = sat_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wraps_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wraps_q <= wraps_d;
      sat_q   <= sat_d;
    end
  end

  assign busy = (state_q == S_RUN);

  // Head register drives out_data directly; a pop shifts the tail forward.
  assign pop = (fcnt_q != 2'd0) && out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fcnt_d = fcnt_q;
    case (fcnt_q)
      2'd0: begin
        if (push) begin
          head_d = push_rec;
          fcnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          head_d = push_rec;
        end else if (pop) begin
          fcnt_d = 2'd0;
        end else if (push) begin
          tail_d = push_rec;
          fcnt_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_rec;
          end else begin
            fcnt_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      fcnt_q <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign out_valid = (fcnt_q != 2'd0);
  assign out_data  = head_q;

`ifdef ACCUM_MON_DROP_CNT_EN
  logic [7:0] drop_q;
  logic       drop_push;

  assign drop_push = push && (fcnt_q == 2'd2) && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop_push && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule
